// File: rtl/ika2151_noise_mc.sv
// Multi-channel OPM-style noise generator: per-channel frequency divider,
// white/periodic Fibonacci LFSR and signed +/-LEVEL accumulator output.
module ika2151_noise_mc #(
  parameter int unsigned           NCH    = 1,
  parameter int unsigned           LFSR_W = 17,
  parameter int unsigned           TAP    = 3,
  parameter logic [LFSR_W-1:0]     SEED   = LFSR_W'(1),
  parameter int unsigned           FRQ_W  = 5,
  parameter int unsigned           OUT_W  = 14
) (
  input  logic                     i_EMUCLK,
  input  logic                     i_MRST,
  input  logic                     i_phi1_PCEN_n,
  input  logic                     i_CYCLE_12,
  input  logic [NCH-1:0]           i_NEN,
  input  logic [NCH-1:0]           i_MODE,
  input  logic [NCH*FRQ_W-1:0]     i_NFRQ,
  input  logic [NCH*(OUT_W-1)-1:0] i_LEVEL,
  output logic [NCH*OUT_W-1:0]     o_ACC_NOISE,
  output logic [NCH-1:0]           o_STEP,
  output logic                     o_LFO_NOISE
);

  logic                en;
  logic                tick;
  logic [LFSR_W-1:0]   lfsr_q  [NCH];
  logic [FRQ_W-1:0]    cnt_q   [NCH];
  logic [LFSR_W-1:0]   lfsr_nx [NCH];
  logic [OUT_W-1:0]    acc_nx  [NCH];
  logic [NCH-1:0]      wrap;

  assign en   = ~i_phi1_PCEN_n;
  assign tick = en & i_CYCLE_12;

  always_comb begin
    logic             fb;
    logic [FRQ_W-1:0] nfrq;
    logic [OUT_W-1:0] mag;
    fb   = 1'b0;
    nfrq = '0;
    mag  = '0;
    wrap = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      lfsr_nx[k] = '0;
      acc_nx[k]  = '0;
    end
    for (int unsigned k = 0; k < NCH; k++) begin
      nfrq = i_NFRQ[k*FRQ_W +: FRQ_W];
      // P-1 = (2^FRQ_W - 1) - NFRQ, i.e. the bitwise complement of NFRQ
      wrap[k] = (cnt_q[k] >= ~nfrq);
      fb = i_MODE[k] ? lfsr_q[k][0] : (lfsr_q[k][0] ^ lfsr_q[k][TAP]);
      lfsr_nx[k] = (lfsr_q[k] == '0) ? SEED : {fb, lfsr_q[k][LFSR_W-1:1]};
      mag = {1'b0, i_LEVEL[k*(OUT_W-1) +: (OUT_W-1)]};
      if (!i_NEN[k])
        acc_nx[k] = '0;
      else
        acc_nx[k] = lfsr_q[k][0] ? mag : (OUT_W'(0) - mag);
    end
  end

  always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
    if (i_MRST) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        lfsr_q[k] <= SEED;
        cnt_q[k]  <= '0;
      end
      o_ACC_NOISE <= '0;
      o_STEP      <= '0;
      o_LFO_NOISE <= 1'b0;
    end else if (en) begin
      o_LFO_NOISE <= lfsr_q[0][0];
      for (int unsigned k = 0; k < NCH; k++) begin
        o_ACC_NOISE[k*OUT_W +: OUT_W] <= acc_nx[k];
        o_STEP[k] <= 1'b0;
        if (!i_NEN[k]) begin
          cnt_q[k] <= '0;
        end else if (tick) begin
          if (wrap[k]) begin
            cnt_q[k]  <= '0;
            lfsr_q[k] <= lfsr_nx[k];
            o_STEP[k] <= 1'b1;
          end else begin
            cnt_q[k] <= cnt_q[k] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ika2151_noise_mc.sv
// Self-checking bench for ika2151_noise_mc (two channels) against an
// arithmetic reference model run in lockstep, plus directed spacing/period checks.
module tb_ika2151_noise_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pcen_n = 1'b1;
  logic        cyc = 1'b0;
  logic [1:0]  nen = '0;
  logic [1:0]  mode = '0;
  logic [4:0]  nfrq [2];
  logic [12:0] lvl  [2];
  logic [9:0]  nfrq_bus;
  logic [25:0] lvl_bus;
  logic [27:0] acc;
  logic [1:0]  stp;
  logic        lfo;

  assign nfrq_bus = {nfrq[1], nfrq[0]};
  assign lvl_bus  = {lvl[1], lvl[0]};

  ika2151_noise_mc #(
    .NCH(2), .LFSR_W(17), .TAP(3), .SEED(17'h1), .FRQ_W(5), .OUT_W(14)
  ) dut (
    .i_EMUCLK(clk), .i_MRST(rst), .i_phi1_PCEN_n(pcen_n), .i_CYCLE_12(cyc),
    .i_NEN(nen), .i_MODE(mode), .i_NFRQ(nfrq_bus), .i_LEVEL(lvl_bus),
    .o_ACC_NOISE(acc), .o_STEP(stp), .o_LFO_NOISE(lfo)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int unsigned m_lfsr [2];
  int unsigned m_cnt  [2];
  logic [13:0] m_acc  [2];
  logic [1:0]  m_step;
  logic        m_lfo;
  int          tick_no = 0;
  int          last_step = -1;
  int          exp_gap = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned lfsr_adv(input int unsigned s, input logic md);
    int unsigned fb;
    if (s == 0) return 1;
    fb = md ? (s & 1) : ((s ^ (s >> 3)) & 1);
    return (s >> 1) | (fb << 16);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lfsr[k] = 1; m_cnt[k] = 0; m_acc[k] = '0;
    end
    m_step = '0; m_lfo = 1'b0;
  endtask

  task automatic model_edge();
    int unsigned p;
    logic [13:0] lv;
    if (pcen_n) return;
    m_lfo = m_lfsr[0][0];
    for (int k = 0; k < 2; k++) begin
      p  = 32 - int'(nfrq[k]);
      lv = {1'b0, lvl[k]};
      m_step[k] = 1'b0;
      if (!nen[k]) begin
        m_acc[k] = '0; m_cnt[k] = 0;
      end else begin
        m_acc[k] = m_lfsr[k][0] ? lv : 14'(0) - lv;
        if (cyc) begin
          if (m_cnt[k] >= p - 1) begin
            m_cnt[k] = 0; m_lfsr[k] = lfsr_adv(m_lfsr[k], mode[k]); m_step[k] = 1'b1;
          end else begin
            m_cnt[k]++;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("acc0", 32'(acc[13:0]), 32'(m_acc[0]));
    chk("acc1", 32'(acc[27:14]), 32'(m_acc[1]));
    chk("step", 32'(stp), 32'(m_step));
    chk("lfo", 32'(lfo), 32'(m_lfo));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    if (!pcen_n && cyc) tick_no++;
    #1;
    check_all();
    if (stp[0]) begin
      if (exp_gap != 0 && last_step >= 0) chk("gap", 32'(tick_no - last_step), 32'(exp_gap));
      last_step = tick_no;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic        seq [34];
    logic [27:0] saved_acc;
    logic [1:0]  saved_stp;
    logic        saved_lfo;
    int          guard;

    nfrq[0] = 5'd31; nfrq[1] = 5'd20; lvl[0] = 13'd100; lvl[1] = 13'd500;
    model_reset();
    #1 rst = 1'b1;
    #2;
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_step", 32'(stp), 32'd0);
    chk("rst_lfo", 32'(lfo), 32'd0);

    // T1: one step per edge, +100 first then LFSR-driven signs
    nen = 2'b11; mode = 2'b00; cyc = 1'b1; pcen_n = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    cycle();
    chk("t1_first", 32'(acc[13:0]), 32'h0064);
    chk("t1_step", 32'(stp[0]), 32'd1);
    run(199);

    // T2: spacing 32 for NFRQ=0, then 16
    nfrq[0] = 5'd0; last_step = -1; exp_gap = 32;
    run(100);
    nfrq[0] = 5'd16; last_step = -1; exp_gap = 16;
    run(60);

    // T3: periodic mode rotates with period 17, then back to white
    nfrq[0] = 5'd31; exp_gap = 0; mode[0] = 1'b1;
    run(3);
    for (int i = 0; i < 34; i++) begin
      cycle();
      seq[i] = lfo;
    end
    for (int i = 0; i < 17; i++) chk("t3_period", 32'(seq[i]), 32'(seq[i+17]));
    mode[0] = 1'b0;
    run(40);

    // T4: raising NFRQ mid-count steps on the next tick
    nfrq[0] = 5'd0; guard = 0;
    while (m_cnt[0] != 20 && guard < 64) begin
      cycle();
      guard++;
    end
    chk("t4_reach20", 32'(m_cnt[0]), 32'd20);
    nfrq[0] = 5'd31;
    cycle();
    chk("t4_step", 32'(stp[0]), 32'd1);
    exp_gap = 1;
    run(3);
    nfrq[0] = 5'd0; exp_gap = 32;
    run(70);

    // T5: disable mid-count, re-enable, then clock-enable gating
    exp_gap = 0;
    run(7);
    nen[0] = 1'b0;
    cycle();
    chk("t5_acc_off", 32'(acc[13:0]), 32'd0);
    chk("t5_step_off", 32'(stp[0]), 32'd0);
    run(5);
    nen[0] = 1'b1; last_step = tick_no; exp_gap = 32;
    run(70);
    exp_gap = 0;
    saved_acc = acc; saved_stp = stp; saved_lfo = lfo;
    pcen_n = 1'b1;
    run(6);
    chk("t5_hold_acc", 32'(acc), 32'(saved_acc));
    chk("t5_hold_step", 32'(stp), 32'(saved_stp));
    chk("t5_hold_lfo", 32'(lfo), 32'(saved_lfo));
    pcen_n = 1'b0;

    // Randomized run over both channels
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) begin
        for (int k = 0; k < 2; k++) begin
          nen[k]  = ($urandom_range(0, 7) != 0);
          mode[k] = $urandom_range(0, 1);
          case ($urandom_range(0, 3))
            0: nfrq[k] = 5'd0;
            1: nfrq[k] = 5'd31;
            default: nfrq[k] = 5'($urandom_range(0, 31));
          endcase
          case ($urandom_range(0, 3))
            0: lvl[k] = 13'd0;
            1: lvl[k] = 13'h1FFF;
            default: lvl[k] = 13'($urandom_range(0, 8191));
          endcase
        end
      end
      pcen_n = ($urandom_range(0, 3) == 0);
      cyc    = $urandom_range(0, 1);
      cycle();
    end

    // T6: asynchronous reset between edges
    rst = 1'b1;
    #1;
    chk("t6_acc", 32'(acc), 32'd0);
    chk("t6_step", 32'(stp), 32'd0);
    chk("t6_lfo", 32'(lfo), 32'd0);
    model_reset();
    #1 rst = 1'b0;
    nen = 2'b11; mode = 2'b00; pcen_n = 1'b0; cyc = 1'b1;
    nfrq[0] = 5'd31; nfrq[1] = 5'd7; lvl[0] = 13'd100; lvl[1] = 13'd1234;
    cycle();
    chk("t6_seed", 32'(acc[13:0]), 32'h0064);
    run(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
